// File: rtl/guess_game_core_if.sv
// Player-facing signal bundle for guess_game_core.
//   pb      : push button, active-low, asynchronous to clk
//   sw      : slide-switch guess value, asynchronous
//   seg0..5 : active-low 7-segment digits (target ones/tens, score ones/tens,
//             timer ones/tens), bit6=g .. bit0=a
//   state_o : game state, 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
// master = board/player side, slave = game core.
interface guess_game_core_if #(
  parameter int unsigned SW_W = 7
);
  logic            pb;
  logic [SW_W-1:0] sw;
  logic [6:0]      seg0;
  logic [6:0]      seg1;
  logic [6:0]      seg2;
  logic [6:0]      seg3;
  logic [6:0]      seg4;
  logic [6:0]      seg5;
  logic [1:0]      state_o;

  modport master (
    output pb, sw,
    input  seg0, seg1, seg2, seg3, seg4, seg5, state_o
  );

  modport slave (
    input  pb, sw,
    output seg0, seg1, seg2, seg3, seg4, seg5, state_o
  );
endinterface

// File: rtl/guess_game_core.sv
// Number-guessing game core: pseudo-random target 1..MAX_TARGET, player
// matches it on the switches to score, BCD round timer to ROUND_SEC,
// single start/pause/restart button, six active-low 7-segment digits.
// Single clock domain; the one-second timebase is a clock-enable tick.
// Ports:
//   clk  : board clock
//   rst  : asynchronous active-low reset
//   bus  : guess_game_core_if.slave (pb, sw in; seg0..seg5, state_o out)
// Optional feature: define GUESS_HISCORE_EN to keep a best-score register
// that is shown on the target digits while IDLE.
module guess_game_core #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned SW_W       = 7,
  parameter int unsigned MAX_TARGET = 30,
  parameter int unsigned ROUND_SEC  = 60,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  guess_game_core_if.slave    bus
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned CMP_W = (SW_W > 7) ? SW_W : 7;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [7:0]       ROUND_BCD  = {4'(ROUND_SEC / 10), 4'(ROUND_SEC % 10)};
  localparam logic [15:0]      LFSR_TAPS  = 16'hB400;
  localparam logic [6:0]       TARGET_RST = 7'((LFSR_SEED % 16'(MAX_TARGET)) + 16'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Active-low segment code for one BCD digit; non-decimal codes blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h18;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Two-digit BCD increment (caller handles the 99 ceiling).
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  state_t            state_q, state_d;
  logic              pb_s1_q, pb_s2_q;
  logic              deb_level_q, deb_level_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [SW_W-1:0]   sw_s1_q, sw_s2_q;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [7:0]        timer_q, timer_d;
  logic [7:0]        score_q, score_d;
  logic [6:0]        target_q, target_d;
`ifdef GUESS_HISCORE_EN
  logic [7:0]        best_q, best_d;
`endif

  logic              press_c;
  logic              tick_c;
  logic              hit_c;
  logic [6:0]        cand_c;
  logic [6:0]        draw_c;
  logic [7:0]        timer_inc_c;
  logic [3:0]        tgt_tens_c;
  logic [3:0]        tgt_ones_c;

  // Button debounce: accept a new level after DEB_CYCLES differing samples.
  always_comb begin
    deb_level_d = deb_level_q;
    deb_cnt_d   = '0;
    if (pb_s2_q != deb_level_q) begin
      if (deb_cnt_q == DEB_LAST) deb_level_d = pb_s2_q;
      else                       deb_cnt_d   = deb_cnt_q + DEB_W'(1);
    end
    press_c = deb_level_q & ~deb_level_d;
  end

  // Free-running Galois LFSR and target draw that never repeats the old target.
  always_comb begin
    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    cand_c = 7'(lfsr_q % 16'(MAX_TARGET)) + 7'd1;
    draw_c = (cand_c == target_q) ? 7'(cand_c % 7'(MAX_TARGET)) + 7'd1 : cand_c;
  end

  assign tick_c      = (state_q == ST_RUN) && (div_q == DIV_LAST);
  assign hit_c       = (state_q == ST_RUN) && (CMP_W'(sw_s2_q) == CMP_W'(target_q));
  assign timer_inc_c = bcd_inc(timer_q);

  // Game FSM and datapath next-state.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    timer_d  = timer_q;
    score_d  = score_q;
    target_d = target_q;
`ifdef GUESS_HISCORE_EN
    best_d   = best_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (press_c) begin
          state_d = ST_RUN;
          div_d   = '0;
        end
      end
      ST_RUN: begin
        div_d = tick_c ? '0 : div_q + DIV_W'(1);
        if (hit_c) begin
          if (score_q != 8'h99) score_d = bcd_inc(score_q);
          target_d = draw_c;
        end
        if (tick_c) timer_d = timer_inc_c;
        // Timeout outranks a coincident press.
        if (tick_c && (timer_inc_c == ROUND_BCD)) state_d = ST_DONE;
        else if (press_c)                         state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (press_c) state_d = ST_RUN;
      end
      ST_DONE: begin
        if (press_c) begin
          state_d  = ST_IDLE;
          score_d  = '0;
          timer_d  = '0;
          target_d = draw_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef GUESS_HISCORE_EN
    // BCD digits compare correctly as a plain 8-bit magnitude.
    if ((state_q == ST_RUN) && (state_d == ST_DONE) && (score_d > best_q)) best_d = score_d;
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pb_s1_q     <= 1'b1;
      pb_s2_q     <= 1'b1;
      deb_level_q <= 1'b1;
      deb_cnt_q   <= '0;
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      div_q       <= '0;
      timer_q     <= '0;
      score_q     <= '0;
      target_q    <= TARGET_RST;
`ifdef GUESS_HISCORE_EN
      best_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pb_s1_q     <= bus.pb;
      pb_s2_q     <= pb_s1_q;
      deb_level_q <= deb_level_d;
      deb_cnt_q   <= deb_cnt_d;
      sw_s1_q     <= bus.sw;
      sw_s2_q     <= sw_s1_q;
      lfsr_q      <= lfsr_d;
      div_q       <= div_d;
      timer_q     <= timer_d;
      score_q     <= score_d;
      target_q    <= target_d;
`ifdef GUESS_HISCORE_EN
      best_q      <= best_d;
`endif
    end
  end

  // Display decode of registered state.
  always_comb begin
    tgt_tens_c = 4'(target_q / 7'd10);
    tgt_ones_c = 4'(target_q % 7'd10);
    bus.seg0   = 7'h7F;
    bus.seg1   = 7'h7F;
    if ((state_q == ST_RUN) || (state_q == ST_DONE)) begin
      bus.seg0 = seg7(tgt_ones_c);
      bus.seg1 = seg7(tgt_tens_c);
    end
`ifdef GUESS_HISCORE_EN
    else if (state_q == ST_IDLE) begin
      bus.seg0 = seg7(best_q[3:0]);
      bus.seg1 = seg7(best_q[7:4]);
    end
`endif
    bus.seg2    = seg7(score_q[3:0]);
    bus.seg3    = seg7(score_q[7:4]);
    bus.seg4    = seg7(timer_q[3:0]);
    bus.seg5    = seg7(timer_q[7:4]);
    bus.state_o = state_q;
  end

endmodule

// File: tb/tb_guess_game_core.sv
// Self-checking bench for guess_game_core: reset, debounce, hits, pause,
// timeout, round restart, score saturation (second instance), high score.
module tb_guess_game_core;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  guess_game_core_if #(.SW_W(7)) gif ();
  guess_game_core_if #(.SW_W(8)) sif ();

  guess_game_core #(
    .TICK_DIV(10), .DEB_CYCLES(4), .SW_W(7), .MAX_TARGET(30),
    .ROUND_SEC(5), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst_n), .bus(gif)
  );

  guess_game_core #(
    .TICK_DIV(100), .DEB_CYCLES(4), .SW_W(8), .MAX_TARGET(99),
    .ROUND_SEC(99), .LFSR_SEED(16'h1D2B)
  ) u_sat (
    .clk(clk), .rst(rst_n), .bus(sif)
  );

  int checks = 0;
  int errors = 0;
  int sb_q[$];

  typedef struct {
    int mode;       // 0 miss (sw=0), 1 match shown target, 2 hold previous sw
    int exp_score;
  } hit_vec_t;
  hit_vec_t vecs [5];

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) t=%0t", name, act, act, exp, exp, $time);
    end
  endfunction

  function automatic logic [6:0] exp_seg(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h18;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int seg_dig(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (exp_seg(i) == s) return i;
    return -1;
  endfunction

  function automatic int disp_val(input logic [6:0] tens, input logic [6:0] ones);
    int t, o;
    t = seg_dig(tens);
    o = seg_dig(ones);
    if (t < 0 || o < 0) return -1;
    return 10 * t + o;
  endfunction

  // Expected target digit while IDLE: best score if that feature is built in.
  function automatic logic [6:0] idle_tgt_seg(input int best_digit);
`ifdef GUESS_HISCORE_EN
    return exp_seg(best_digit);
`else
    return (best_digit >= 0) ? 7'h7F : 7'h7F;
`endif
  endfunction

  task automatic press(input bit sat);
    if (sat) sif.pb = 1'b0; else gif.pb = 1'b0;
    repeat (7) @(negedge clk);
    if (sat) sif.pb = 1'b1; else gif.pb = 1'b1;
    repeat (7) @(negedge clk);
  endtask

  task automatic wait_state(input int st, input int budget, input string name);
    int n = 0;
    while (int'(gif.state_o) != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(gif.state_o), st);
  endtask

  task automatic wait_timer(input int v, input int budget, input string name);
    int n = 0;
    while (disp_val(gif.seg5, gif.seg4) != v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, disp_val(gif.seg5, gif.seg4), v);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_seg0"}, int'(gif.seg0), int'(idle_tgt_seg(0)));
    chk({tag, "_seg1"}, int'(gif.seg1), int'(idle_tgt_seg(0)));
    chk({tag, "_seg2"}, int'(gif.seg2), 32'h40);
    chk({tag, "_seg3"}, int'(gif.seg3), 32'h40);
    chk({tag, "_seg4"}, int'(gif.seg4), 32'h40);
    chk({tag, "_seg5"}, int'(gif.seg5), 32'h40);
    chk({tag, "_state"}, int'(gif.state_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, prev_t, exp_s, sc;

    vecs[0] = '{1, 1};
    vecs[1] = '{0, 1};
    vecs[2] = '{1, 2};
    vecs[3] = '{2, 2};
    vecs[4] = '{1, 3};

    rst_n  = 1'b0;
    gif.pb = 1'b1;
    gif.sw = '0;
    sif.pb = 1'b1;
    sif.sw = '0;
    #12;
    chk_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Saturation and zero-extension on the 8-bit-switch instance.
    press(1'b1);
    chk("sat_run", int'(sif.state_o), 1);
    exp_s = 0;
    for (int i = 0; i <= 100; i++) begin
      t = disp_val(sif.seg1, sif.seg0);
      if (i == 50) begin
        sif.sw = 8'h80 | 8'(t);
      end else begin
        sif.sw = 8'(t);
        exp_s = (exp_s < 99) ? exp_s + 1 : 99;
      end
      sb_q.push_back(exp_s);
      repeat (4) @(negedge clk);
      chk("sat_score", disp_val(sif.seg3, sif.seg2), sb_q.pop_front());
    end
    chk("sat_seg2", int'(sif.seg2), 32'h18);
    chk("sat_seg3", int'(sif.seg3), 32'h18);

    // Debounce: 3-cycle glitch ignored, 6-cycle press starts the round.
    gif.pb = 1'b0;
    repeat (3) @(negedge clk);
    gif.pb = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_idle", int'(gif.state_o), 0);
    gif.pb = 1'b0;
    repeat (6) @(negedge clk);
    gif.pb = 1'b1;
    wait_state(1, 20, "press_run");
    repeat (8) @(negedge clk);
    t = disp_val(gif.seg1, gif.seg0);
    chk("target_range", int'(t >= 1 && t <= 30), 1);

    // Pause at timer 02.
    wait_timer(2, 40, "timer_02");
    t = disp_val(gif.seg1, gif.seg0);
    press(1'b0);
    chk("pause_state", int'(gif.state_o), 2);
    repeat (50) @(negedge clk);
    chk("pause_timer", disp_val(gif.seg5, gif.seg4), 2);
    chk("pause_seg0", int'(gif.seg0), 32'h7F);
    chk("pause_seg1", int'(gif.seg1), 32'h7F);
    gif.sw = 7'(t);
    repeat (8) @(negedge clk);
    chk("pause_nohit", disp_val(gif.seg3, gif.seg2), 0);
    gif.sw = '0;
    repeat (3) @(negedge clk);
    press(1'b0);
    chk("resume_state", int'(gif.state_o), 1);
    wait_timer(3, 20, "resume_timer");

    // Timeout.
    wait_state(3, 60, "done_state");
    chk("done_seg5", int'(gif.seg5), 32'h40);
    chk("done_seg4", int'(gif.seg4), 32'h12);
    t = disp_val(gif.seg1, gif.seg0);
    gif.sw = 7'(t);
    repeat (8) @(negedge clk);
    chk("done_nohit", disp_val(gif.seg3, gif.seg2), 0);
    chk("done_timer_hold", disp_val(gif.seg5, gif.seg4), 5);
    gif.sw = '0;
    repeat (3) @(negedge clk);
    press(1'b0);
    wait_state(0, 10, "restart_idle");
    chk("restart_timer", disp_val(gif.seg5, gif.seg4), 0);
    chk("idle1_seg0", int'(gif.seg0), int'(idle_tgt_seg(0)));

    // Round 2: table of hit/miss/hold steps, scoreboarded.
    press(1'b0);
    chk("r2_run", int'(gif.state_o), 1);
    foreach (vecs[k]) begin
      prev_t = disp_val(gif.seg1, gif.seg0);
      if (vecs[k].mode == 0) gif.sw = '0;
      else if (vecs[k].mode == 1) gif.sw = 7'(prev_t);
      sb_q.push_back(vecs[k].exp_score);
      repeat (4) @(negedge clk);
      sc = sb_q.pop_front();
      chk("hit_score", disp_val(gif.seg3, gif.seg2), sc);
      chk("hit_seg2", int'(gif.seg2), int'(exp_seg(sc % 10)));
      chk("hit_seg3", int'(gif.seg3), int'(exp_seg(sc / 10)));
      if (vecs[k].mode == 1) begin
        t = disp_val(gif.seg1, gif.seg0);
        chk("new_target_differs", int'(t != prev_t && t >= 1 && t <= 30), 1);
      end
    end
    gif.sw = '0;
    wait_state(3, 60, "r2_done");
    press(1'b0);
    wait_state(0, 10, "r2_idle");
    chk("r2_score_clr", disp_val(gif.seg3, gif.seg2), 0);
    chk("r2_best_seg0", int'(gif.seg0), int'(idle_tgt_seg(3)));
    chk("r2_best_seg1", int'(gif.seg1), int'(idle_tgt_seg(0)));

    // Round 3: lower score must not replace the best.
    press(1'b0);
    t = disp_val(gif.seg1, gif.seg0);
    gif.sw = 7'(t);
    repeat (5) @(negedge clk);
    chk("r3_score", disp_val(gif.seg3, gif.seg2), 1);
    gif.sw = '0;
    wait_state(3, 60, "r3_done");
    press(1'b0);
    wait_state(0, 10, "r3_idle");
    chk("r3_best_seg0", int'(gif.seg0), int'(idle_tgt_seg(3)));

    // Asynchronous reset in the middle of a round.
    press(1'b0);
    repeat (3) @(negedge clk);
    chk("pre_reset_run", int'(gif.state_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrun");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
